// File: rtl/bec_pkg.sv
// Shared constants and FSM encoding for the BEC ladder controller.
// Pure definitions; no latency or backpressure.
package bec_pkg;
    localparam int BEC_KEY_W    = 163;
    localparam int BEC_WDOG_CYC = 4096;
    localparam int BEC_CNT_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_RUN   = 3'b001,
        ST_DRAIN = 3'b010,
        ST_DONE  = 3'b011,
        ST_ERR   = 3'b100
    } state_t;
endpackage

// File: rtl/bec_watchdog.sv
// Loadable down-counter; zero_o flags that the count reaches 0 on the coming edge.
// Single-cycle update, no backpressure.
module bec_watchdog #(
    parameter int LOAD_VAL = 4096,
    parameter int CW       = $clog2(LOAD_VAL + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CW'(LOAD_VAL);
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Looking at the next value lets the FSM flag expiry on the same edge the count hits 0.
    assign zero_o = (cnt_d == '0);
endmodule

// File: rtl/bec_ladder_ctrl.sv
// Sequences key bits into a BEC ladder core, captures its result, and guards it with a watchdog.
// Outputs registered (1-cycle); the core paces consumption through core_next_key.
module bec_ladder_ctrl
    import bec_pkg::*;
#(
    parameter int KEY_W    = BEC_KEY_W,
    parameter int WDOG_CYC = BEC_WDOG_CYC
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic [KEY_W-1:0]     key_in,
    input  logic                 key_load,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 clear,
    output logic                 core_enable,
    output logic                 core_ki,
    input  logic                 core_next_key,
    input  logic                 core_done,
    input  logic [KEY_W-1:0]     core_wout,
    input  logic [KEY_W-1:0]     core_zout,
    output logic [KEY_W-1:0]     wout,
    output logic [KEY_W-1:0]     zout,
    output logic                 busy,
    output logic                 done,
    output logic                 result_valid,
    output logic                 error,
    output logic [BEC_CNT_W-1:0] bit_cnt
);
    localparam logic [BEC_CNT_W-1:0] CNT_FULL = BEC_CNT_W'(KEY_W);
    localparam logic [BEC_CNT_W-1:0] CNT_LAST = BEC_CNT_W'(KEY_W - 1);

    state_t               state_q, state_d;
    logic [KEY_W-1:0]     key_q, key_d;
    logic [KEY_W-1:0]     wout_q, wout_d, zout_q, zout_d;
    logic [BEC_CNT_W-1:0] bit_cnt_q, bit_cnt_d, cnt_inc, cnt_after;
    logic                 rv_q, rv_d;
    logic                 en_q, en_d;
    logic                 wd_load, wd_dec, wd_zero;

    bec_watchdog #(.LOAD_VAL(WDOG_CYC)) u_wdog (
        .clk_i  (wb_clk_i),
        .rst_i  (wb_rst_i),
        .load_i (wd_load),
        .dec_i  (wd_dec),
        .zero_o (wd_zero)
    );

    assign cnt_inc   = (bit_cnt_q == CNT_FULL) ? bit_cnt_q : bit_cnt_q + 1'b1;
    assign cnt_after = core_next_key ? cnt_inc : bit_cnt_q;

    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        wout_d    = wout_q;
        zout_d    = zout_q;
        bit_cnt_d = bit_cnt_q;
        rv_d      = rv_q;
        wd_load   = 1'b0;
        wd_dec    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (key_load) key_d = key_in;
                if (start) begin
                    state_d   = ST_RUN;
                    bit_cnt_d = '0;
                    rv_d      = 1'b0;
                    wd_load   = 1'b1;
                end
            end
            ST_RUN: begin
                wd_dec = 1'b1;
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    if (core_next_key) begin
                        key_d     = key_q >> 1;
                        bit_cnt_d = cnt_inc;
                        wd_load   = 1'b1;
                    end
                    if (core_done && core_next_key && (cnt_inc == CNT_FULL)) begin
                        state_d = ST_DONE;
                        wout_d  = core_wout;
                        zout_d  = core_zout;
                        rv_d    = 1'b1;
                    end else if (core_done && (cnt_after < CNT_LAST)) begin
                        state_d = ST_ERR;
                    end else if (core_next_key && (cnt_inc == CNT_FULL)) begin
                        state_d = ST_DRAIN;
                    end else if (wd_zero) begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_DRAIN: begin
                wd_dec = 1'b1;
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (core_next_key) begin
                    state_d = ST_ERR;
                end else if (core_done) begin
                    state_d = ST_DONE;
                    wout_d  = core_wout;
                    zout_d  = core_zout;
                    rv_d    = 1'b1;
                end else if (wd_zero) begin
                    state_d = ST_ERR;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  if (clear) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        en_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= ST_IDLE;
            key_q     <= '0;
            wout_q    <= '0;
            zout_q    <= '0;
            bit_cnt_q <= '0;
            rv_q      <= 1'b0;
            en_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            key_q     <= key_d;
            wout_q    <= wout_d;
            zout_q    <= zout_d;
            bit_cnt_q <= bit_cnt_d;
            rv_q      <= rv_d;
            en_q      <= en_d;
        end
    end

    assign core_enable  = en_q;
    assign core_ki      = key_q[0];
    assign wout         = wout_q;
    assign zout         = zout_q;
    assign busy         = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done         = (state_q == ST_DONE);
    assign result_valid = rv_q;
    assign error        = (state_q == ST_ERR);
    assign bit_cnt      = bit_cnt_q;
endmodule

// File: tb/tb_bec_ladder_ctrl.sv
// Directed bench for bec_ladder_ctrl at default parameters (KEY_W=163, WDOG_CYC=4096).
module tb_bec_ladder_ctrl;
    localparam int KW = 163;
    localparam int WD = 4096;

    logic          wb_clk_i = 1'b0;
    logic          wb_rst_i = 1'b1;
    logic [KW-1:0] key_in = '0;
    logic          key_load = 1'b0, start = 1'b0, abort = 1'b0, clear = 1'b0;
    logic          core_next_key = 1'b0, core_done = 1'b0;
    logic [KW-1:0] core_wout = '0, core_zout = '0;
    logic          core_enable, core_ki, busy, done, result_valid, error;
    logic [KW-1:0] wout, zout;
    logic [7:0]    bit_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    bec_ladder_ctrl dut (
        .wb_clk_i      (wb_clk_i),
        .wb_rst_i      (wb_rst_i),
        .key_in        (key_in),
        .key_load      (key_load),
        .start         (start),
        .abort         (abort),
        .clear         (clear),
        .core_enable   (core_enable),
        .core_ki       (core_ki),
        .core_next_key (core_next_key),
        .core_done     (core_done),
        .core_wout     (core_wout),
        .core_zout     (core_zout),
        .wout          (wout),
        .zout          (zout),
        .busy          (busy),
        .done          (done),
        .result_valid  (result_valid),
        .error         (error),
        .bit_cnt       (bit_cnt)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic pulses(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            repeat (gap - 1) tick();
            core_next_key = 1'b1;
            tick();
            core_next_key = 1'b0;
        end
    endtask

    task automatic start_run(input logic ld, input logic [KW-1:0] k);
        key_in   = k;
        key_load = ld;
        start    = 1'b1;
        tick();
        key_load = 1'b0;
        start    = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (3) tick();
        wb_rst_i = 1'b0;
        chk("rst_en", core_enable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rv", result_valid, 0);
        chk("rst_err", error, 0);
        chk("rst_cnt", bit_cnt, 0);
        chk("rst_wout", wout, 0);
        chk("rst_ki", core_ki, 0);

        // Nominal run: key 1, pulses every 10 cycles, done 5 cycles after last
        key_in = 163'h1; key_load = 1'b1; tick(); key_load = 1'b0;
        start_run(1'b0, '0);
        chk("nom_en", core_enable, 1);
        chk("nom_busy", busy, 1);
        chk("nom_cnt0", bit_cnt, 0);
        chk("nom_ki0", core_ki, 1);
        pulses(KW, 10);
        chk("nom_cnt", bit_cnt, 163);
        chk("nom_drain_busy", busy, 1);
        chk("nom_drain_ki", core_ki, 0);
        repeat (4) tick();
        chk("nom_predone", done, 0);
        core_done = 1'b1; core_wout = 163'hA5; core_zout = 163'h5A;
        tick();
        core_done = 1'b0; core_wout = '0; core_zout = '0;
        chk("nom_done", done, 1);
        chk("nom_wout", wout, 163'hA5);
        chk("nom_zout", zout, 163'h5A);
        chk("nom_rv", result_valid, 1);
        chk("nom_en_off", core_enable, 0);
        chk("nom_cnt_end", bit_cnt, 163);
        tick();
        chk("nom_done_1cyc", done, 0);
        chk("nom_idle", busy, 0);
        chk("nom_rv_hold", result_valid, 1);

        // Key bit order: 163'h5 gives 1,0,1 then zeros
        key_in = 163'h5; key_load = 1'b1; tick(); key_load = 1'b0;
        start_run(1'b0, '0);
        chk("kb_rv_clr", result_valid, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            core_next_key = 1'b1;
            chk($sformatf("kb_ki%0d", i), core_ki, (i == 0 || i == 2) ? 1 : 0);
            tick();
            core_next_key = 1'b0;
        end
        chk("kb_cnt", bit_cnt, 6);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("kb_abort_idle", busy, 0);

        // Premature done at bit_cnt=50, sticky error, start ignored, clear
        start_run(1'b0, '0);
        pulses(50, 2);
        chk("pre_cnt", bit_cnt, 50);
        core_done = 1'b1; tick(); core_done = 1'b0;
        chk("pre_err", error, 1);
        chk("pre_en", core_enable, 0);
        chk("pre_busy", busy, 0);
        start = 1'b1; tick(); start = 1'b0;
        chk("pre_sticky", error, 1);
        chk("pre_no_start", busy, 0);
        clear = 1'b1; tick(); clear = 1'b0;
        chk("pre_clr_err", error, 0);
        chk("pre_clr_busy", busy, 0);

        // Abort at bit_cnt=80 with core_done in the same cycle
        start_run(1'b0, '0);
        pulses(80, 2);
        chk("ab_cnt", bit_cnt, 80);
        abort = 1'b1; core_done = 1'b1; core_wout = '1; core_zout = '1;
        tick();
        abort = 1'b0; core_done = 1'b0; core_wout = '0; core_zout = '0;
        chk("ab_busy", busy, 0);
        chk("ab_done", done, 0);
        chk("ab_en", core_enable, 0);
        chk("ab_err", error, 0);
        chk("ab_wout", wout, 163'hA5);
        chk("ab_zout", zout, 163'h5A);
        tick();
        chk("ab_done2", done, 0);

        // next_key and done together on bit 163: straight to DONE
        start_run(1'b0, '0);
        pulses(KW - 1, 2);
        chk("dir_cnt162", bit_cnt, 162);
        chk("dir_busy", busy, 1);
        tick();
        core_next_key = 1'b1; core_done = 1'b1;
        core_wout = 163'h123; core_zout = 163'h456;
        tick();
        core_next_key = 1'b0; core_done = 1'b0; core_wout = '0; core_zout = '0;
        chk("dir_done", done, 1);
        chk("dir_cnt", bit_cnt, 163);
        chk("dir_wout", wout, 163'h123);
        chk("dir_zout", zout, 163'h456);
        chk("dir_rv", result_valid, 1);
        chk("dir_en", core_enable, 0);
        tick();

        // key_load with start uses the new key; key_load ignored in RUN; reset at 100
        start_run(1'b1, 163'h3);
        chk("kl_ki0", core_ki, 1);
        key_in = '1; key_load = 1'b1; tick(); key_load = 1'b0;
        chk("kl_ign_ki0", core_ki, 1);
        pulses(1, 2);
        chk("kl_ki1", core_ki, 1);
        pulses(1, 2);
        chk("kl_ki2", core_ki, 0);
        pulses(98, 2);
        chk("mr_cnt", bit_cnt, 100);
        wb_rst_i = 1'b1; tick(); wb_rst_i = 1'b0;
        chk("mr_en", core_enable, 0);
        chk("mr_busy", busy, 0);
        chk("mr_cnt0", bit_cnt, 0);
        chk("mr_rv", result_valid, 0);
        chk("mr_wout", wout, 0);
        chk("mr_zout", zout, 0);
        chk("mr_ki", core_ki, 0);
        chk("mr_err", error, 0);
        chk("mr_done", done, 0);

        // Watchdog: no next_key for WDOG_CYC cycles after start
        start_run(1'b0, '0);
        repeat (WD - 1) tick();
        chk("wd_before", error, 0);
        chk("wd_busy", busy, 1);
        tick();
        chk("wd_err", error, 1);
        chk("wd_en", core_enable, 0);
        clear = 1'b1; tick(); clear = 1'b0;
        chk("wd_clr", error, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
